fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
Instruction-fetch controller that drives the program ROM address and hands 42-bit instruction words to the decode/execute stage with a valid/ready handshake. It owns the program counter and handles branch redirects from execute, decode back-pressure and halt. It sits between the asynchronous-read program ROM and the CPU decoder, and is the only block that drives the ROM address.

Parameters:
ADDR_W, 8, ROM address / PC width
DATA_W, 42, instruction word width
RESET_PC, 0, PC value after reset

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
run  input  1  start fetching; sampled only in IDLE
rom_addr  output  ADDR_W  ROM address, combinational copy of pc
rom_data  input  DATA_W  ROM read data, valid in the same cycle as rom_addr
inst_out  output  DATA_W  registered instruction to decoder
inst_pc  output  ADDR_W  address inst_out was fetched from
inst_valid  output  1  inst_out holds an unconsumed instruction
inst_ready  input  1  decoder accepts inst_out this cycle
br_valid  input  1  execute requests a redirect (1-cycle pulse)
br_addr  input  ADDR_W  redirect target
halt_req  input  1  execute requests a stop (1-cycle pulse)
halted  output  1  sequencer is in HALT

Behaviour:
- One clock, clk. Reset is asynchronous and active-high on rst; no synchronous reset path.
- Reset values: pc=RESET_PC, state=IDLE, inst_out=0, inst_pc=0, inst_valid=0, halted=0. rom_addr follows pc, so it is RESET_PC.
- States: IDLE, FETCH, HALT. halted=1 only in HALT.
- IDLE: inst_valid=0. If run=1, go to FETCH; the first fetch happens in the first FETCH cycle, not the IDLE cycle.
- FETCH, load condition is load = !inst_valid || inst_ready.
  - When load=1: inst_out<=rom_data, inst_pc<=pc, inst_valid<=1, pc<=pc+1.
  - The PC wraps modulo 2^ADDR_W, so 255 goes to 0 with no flag.
  - When load=0 (stall): pc, inst_out and inst_pc hold.
- Latency: an address presented in cycle N appears on inst_out in cycle N+1. Sustained throughput is 1 instruction/cycle while inst_ready=1.
- Handshake: a transfer happens when inst_valid && inst_ready. inst_out must stay stable while inst_valid=1 and inst_ready=0.
- Branch (br_valid=1 in FETCH):
  - pc<=br_addr and inst_valid<=0, flushing the held or in-flight word regardless of inst_ready.
  - No load occurs that cycle.
  - The next cycle fetches br_addr, so br_addr's word is valid 2 cycles after the br_valid edge.
  - br_addr may equal pc or any value, including the wrap boundary.
- Halt (halt_req=1 in FETCH): go to HALT, inst_valid<=0, pc holds its current value, no load.
- Simultaneous br_valid and halt_req: halt wins and the branch is discarded.
- HALT: absorbing; run, br_valid and halt_req are ignored. Only rst leaves HALT.
- br_valid or halt_req in IDLE: ignored.
- rst asserted mid-operation (any state, any stall): all registers return to reset values immediately, with no clock needed.
- rom_addr is purely combinational from pc; no other combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg holds:
  - INST_W=42 and ADDR_W=8
  - instruction field positions: imm flag [41], opcode [40:36], dst [35:28], src [27:25], flag [24], imm [23:0]
  - the fetch state enum (IDLE/FETCH/HALT)
- Fields are defined for decoder use; the sequencer does not decode opcodes.
- One natural sub-module, pc_counter: holds the PC register and selects between load, increment and hold.
- The state machine and instruction register stay in fetch_sequencer.

Test Plan:
- Reset then run=1, ROM[0..3]=A,B,C,D, inst_ready=1 → A/pc0 valid at cycle 2 after run, then B, C, D on consecutive cycles; rom_addr 0,1,2,3,4.
- Stall: inst_ready=0 for 3 cycles while B is valid → inst_out=B and inst_pc=1 held, rom_addr=2 held; after release B transfers, then C follows next cycle.
- Branch: br_valid=1, br_addr=0x80 while C is valid and inst_ready=0 → inst_valid=0 next cycle, rom_addr=0x80, ROM[0x80] valid the cycle after with inst_pc=0x80.
- Wrap: br_addr=0xFE, free-running → inst_pc sequence 0xFE, 0xFF, 0x00, 0x01.
- Halt with simultaneous br_valid (br_addr=0x10) → halted=1 and inst_valid=0 next cycle, pc unchanged; later run/br_valid pulses have no effect.
- Async reset asserted between clock edges during a stream → inst_valid=0, rom_addr=0 and halted=0 before the next edge; run=1 restarts from address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU widths, instruction field positions and fetch state encoding
package cpu_pkg;

  localparam int INST_W = 42;
  localparam int ADDR_W = 8;

  // Instruction field positions; decoded downstream, not by the fetch path.
  localparam int F_IMMF_BIT = 41;
  localparam int F_OPC_HI   = 40;
  localparam int F_OPC_LO   = 36;
  localparam int F_DST_HI   = 35;
  localparam int F_DST_LO   = 28;
  localparam int F_SRC_HI   = 27;
  localparam int F_SRC_LO   = 25;
  localparam int F_FLAG_BIT = 24;
  localparam int F_IMM_HI   = 23;
  localparam int F_IMM_LO   = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pc_counter.sv
// rtl/pc_counter.sv - program counter with branch load, increment and hold
module pc_counter #(
  parameter int                ADDR_W   = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic              inc,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [ADDR_W-1:0] pc
);

  // Load has priority; the increment wraps naturally at 2^ADDR_W.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (ld) begin
      pc <= ld_addr;
    end else if (inc) begin
      pc <= pc + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - instruction fetch controller feeding the decoder over valid/ready
module fetch_sequencer #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 42,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] inst_out,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  input  logic              br_valid,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              halt_req,
  output logic              halted
);

  import cpu_pkg::*;

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic              in_fetch;
  logic              load;
  logic              take_br;
  logic              do_load;

  // Halt outranks a same-cycle branch, and both suppress the load.
  assign in_fetch = (state == ST_FETCH);
  assign load     = !inst_valid || inst_ready;
  assign take_br  = in_fetch && br_valid && !halt_req;
  assign do_load  = in_fetch && !br_valid && !halt_req && load;

  assign rom_addr = pc;

  pc_counter #(
    .ADDR_W  (ADDR_W),
    .RESET_PC(RESET_PC)
  ) u_pc (
    .clk    (clk),
    .rst    (rst),
    .ld     (take_br),
    .inc    (do_load),
    .ld_addr(br_addr),
    .pc     (pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      inst_out   <= '0;
      inst_pc    <= '0;
      inst_valid <= 1'b0;
      halted     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          inst_valid <= 1'b0;
          if (run) state <= ST_FETCH;
        end
        ST_FETCH: begin
          if (halt_req) begin
            state      <= ST_HALT;
            inst_valid <= 1'b0;
            halted     <= 1'b1;
          end else if (br_valid) begin
            inst_valid <= 1'b0;
          end else if (load) begin
            inst_out   <= rom_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
          end
        end
        ST_HALT: begin
          halted <= 1'b1;
        end
        default: begin
          state      <= ST_IDLE;
          inst_valid <= 1'b0;
          halted     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - randomized self-checking bench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [7:0]  rom_addr;
  logic [41:0] rom_data;
  logic [41:0] inst_out;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        br_valid;
  logic [7:0]  br_addr;
  logic        halt_req;
  logic        halted;

  logic [41:0] rom [256];
  assign rom_data = rom[rom_addr];

  fetch_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .inst_out  (inst_out),
    .inst_pc   (inst_pc),
    .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .br_valid  (br_valid),
    .br_addr   (br_addr),
    .halt_req  (halt_req),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0=idle, 1=fetching, 2=halted.
  int          m_mode;
  logic [7:0]  m_pc;
  logic [41:0] m_out;
  logic [7:0]  m_ipc;
  bit          m_valid;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_pc = 8'h00; m_out = '0; m_ipc = 8'h00; m_valid = 0;
    end else if (m_mode == 0) begin
      m_valid = 0;
      if (run) m_mode = 1;
    end else if (m_mode == 1) begin
      if (halt_req) begin
        m_mode = 2; m_valid = 0;
      end else if (br_valid) begin
        m_pc = br_addr; m_valid = 0;
      end else if (!m_valid || inst_ready) begin
        m_out = rom[m_pc]; m_ipc = m_pc; m_valid = 1;
        m_pc = 8'((int'(m_pc) + 1) % 256);
      end
    end
  end

  always @(negedge clk) begin
    chk("rom_addr", 64'(rom_addr), 64'(m_pc));
    chk("inst_valid", 64'(inst_valid), 64'(m_valid));
    chk("halted", 64'(halted), 64'(m_mode == 2));
    if (m_valid) begin
      chk("inst_out", 64'(inst_out), 64'(m_out));
      chk("inst_pc", 64'(inst_pc), 64'(m_ipc));
    end
  end

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", 64'(inst_valid), 64'd0);
    chk("rst_addr", 64'(rom_addr), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
    #1 rst = 1'b0;
  endtask

  localparam logic [41:0] WA = 42'h0AA_0000_0001;
  localparam logic [41:0] WB = 42'h0BB_0000_0002;
  localparam logic [41:0] WC = 42'h0CC_0000_0003;
  localparam logic [41:0] WD = 42'h0DD_0000_0004;
  localparam logic [41:0] W80 = 42'h280_8080_8080;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = {10'($urandom), 32'($urandom)};
    rom[0] = WA; rom[1] = WB; rom[2] = WC; rom[3] = WD; rom[8'h80] = W80;
    rst = 1'b1; run = 0; inst_ready = 0; br_valid = 0; br_addr = 0; halt_req = 0;
    nclk(); nclk();
    chk("reset_inst_out", 64'(inst_out), 64'd0);
    chk("reset_inst_pc", 64'(inst_pc), 64'd0);
    rst = 1'b0;
    run = 1; inst_ready = 1;
    nclk(); run = 0;
    chk("idle_no_valid", 64'(inst_valid), 64'd0);
    nclk();
    chk("first_A", 64'(inst_out), 64'(WA));
    chk("first_A_pc", 64'(inst_pc), 64'd0);
    chk("addr1", 64'(rom_addr), 64'd1);
    nclk();
    chk("B", 64'(inst_out), 64'(WB));
    inst_ready = 0;
    for (int i = 0; i < 3; i++) begin
      nclk();
      chk("stall_B", 64'(inst_out), 64'(WB));
      chk("stall_pc", 64'(inst_pc), 64'd1);
      chk("stall_addr", 64'(rom_addr), 64'd2);
    end
    inst_ready = 1;
    nclk();
    chk("C_after_stall", 64'(inst_out), 64'(WC));
    inst_ready = 0; br_valid = 1; br_addr = 8'h80;
    nclk(); br_valid = 0; inst_ready = 1;
    chk("br_flush", 64'(inst_valid), 64'd0);
    chk("br_addr", 64'(rom_addr), 64'h80);
    nclk();
    chk("br_word", 64'(inst_out), 64'(W80));
    chk("br_pc", 64'(inst_pc), 64'h80);
    br_valid = 1; br_addr = 8'hFE;
    nclk(); br_valid = 0;
    nclk(); chk("wrap_fe", 64'(inst_pc), 64'hFE);
    nclk(); chk("wrap_ff", 64'(inst_pc), 64'hFF);
    nclk(); chk("wrap_00", 64'(inst_pc), 64'h00);
    nclk(); chk("wrap_01", 64'(inst_pc), 64'h01);
    halt_req = 1; br_valid = 1; br_addr = 8'h10;
    nclk(); halt_req = 0; br_valid = 0;
    chk("halt_flag", 64'(halted), 64'd1);
    chk("halt_valid", 64'(inst_valid), 64'd0);
    chk("halt_pc", 64'(rom_addr), 64'h02);
    run = 1; br_valid = 1; br_addr = 8'h33;
    nclk(); nclk();
    run = 0; br_valid = 0;
    chk("halt_absorb_pc", 64'(rom_addr), 64'h02);
    chk("halt_absorb", 64'(halted), 64'd1);
    async_reset();
    nclk(); run = 1; inst_ready = 1;
    nclk(); run = 0;
    nclk();
    chk("restart_A", 64'(inst_out), 64'(WA));
    // Streaming reset: assert between edges with a valid word held.
    async_reset();
    nclk();
    for (int i = 0; i < 3000; i++) begin
      run        = ($urandom_range(0, 3) == 0);
      inst_ready = ($urandom_range(0, 9) < 7);
      br_valid   = ($urandom_range(0, 9) == 0);
      br_addr    = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      halt_req   = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 249) == 0) async_reset();
      nclk();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
